mii_tx_arbiter: RTL and testbench
=================================

# mii_tx_arbiter

Frame-level scheduler that shares the MAC-side MII transmit port (mac_mii_txc domain) between two nibble-stream frame sources. It grants whole frames round-robin, prepends preamble and SFD, enforces the inter-frame gap, and handles source underrun. It drives mac_mii_txen/txer/txd directly into the MII-to-RMII converter's transmit side.

## Interface
- IFG_NIBBLES, 24: minimum txen-low cycles between frames (12 bytes); legal range ≥1.
- PREAMBLE_NIBBLES, 15: count of 4'h5 nibbles before the SFD nibble; legal range ≥1.
- mac_mii_txc  in  1  MII transmit clock; the only clock.
- mac_mii_txrst  in  1  reset, asynchronous, active-high (the converter's transmit reset).
- src0_valid / src1_valid  in  1  source has a nibble on srcN_data.
- src0_ready / src1_ready  out  1  nibble accepted when valid&&ready.
- src0_data / src1_data  in  4  frame nibble, low nibble of each byte first.
- src0_last / src1_last  in  1  final nibble of the frame.
- src0_err / src1_err  in  1  mark this nibble with txer.
- mac_mii_txen  out  1  registered MII transmit enable.
- mac_mii_txer  out  1  registered MII transmit error.
- mac_mii_txd  out  4  registered MII transmit data.
- busy  out  1  high in any state other than IDLE.
- grant_id  out  1  source owning the current or most recent frame.

## Operation
- States: IDLE, PRE, DATA, DRAIN, IFG.
- IDLE: if any srcN_valid, latch grant and go to PRE. If both are valid, grant the source not granted last. After reset src0 has priority. A lone request is granted regardless.
- PRE: emit PREAMBLE_NIBBLES nibbles of 4'h5, then one 4'hD (SFD), with txen=1 and txer=0.
- DATA: srcN_ready = (grant==N) and is combinational on state only. The other source's ready stays 0.
  - On handshake: txd <= data, txen <= 1, txer <= err.
  - If the handshake carries last, go to IFG.
- Underrun (DATA, grantee valid low): emit one nibble txd=0, txen=1, txer=1, then enter DRAIN.
- DRAIN: grantee ready held 1 with txen=0. Discard nibbles until the last handshake, then go to IFG.
- IFG: txen=0, txer=0, txd=0. The counter runs IFG_NIBBLES cycles, then the block returns to IDLE.
- Requests seen during IFG wait; they are not lost because valid is level-held.
- Simultaneous last and a new request from the other source: the grant changes only in IDLE.
- Reset values: all outputs 0 except busy=0 and grant_id=1, so that src0 wins the first tie. State is IDLE and counters are 0.
- Reset mid-frame clears txen asynchronously, with no txer pulse. The source must restart its frame after reset.

## Timing
- T0: IDLE cycle in which a request is visible.
- T1..T(PREAMBLE_NIBBLES): txd=5, txen=1.
- T(PREAMBLE_NIBBLES+1): txd=D. The grantee's ready rises in this same cycle.
- Data latency: a nibble accepted in cycle k appears on txd in cycle k+1.
- Back-to-back: with the next request already pending, exactly IFG_NIBBLES txen-low cycles separate the last data nibble from the next preamble nibble. With no request pending, the gap is longer.
- The underrun error nibble appears in the cycle after the first DATA cycle with valid low.
- Counter width is $clog2(max(IFG_NIBBLES, PREAMBLE_NIBBLES+1)+1). Counters never wrap; they reload on state entry.

## Structure
- Shared package mii_tx_pkg holds:
  - the state enum;
  - MII_PREAMBLE_NIB = 4'h5;
  - MII_SFD_NIB = 4'hD;
  - default IFG_NIBBLES = 24.
- One natural sub-module: mii_rr_arb2. It is a two-requester round-robin grant with a last-grant register, updated only on the IDLE→PRE transition.

## Test plan
- Single frame from src0, nibbles 1,2,3,4 with last on 4:
  - txd 5 ×15, then D, then 1,2,3,4 with txen=1 for 20 cycles;
  - txen=0 for ≥24 cycles afterwards;
  - grant_id=0.
- Both sources valid continuously with 3-nibble frames, starting after reset:
  - grant order src0, src1, src0, src1;
  - exactly 24 txen-low cycles between frames.
- src1 frame 1,2,3,4,5,6 with err on nibble 3: txer=1 only in the cycle txd=3; all else txer=0.
- Underrun: src0 sends 1,2, drops valid for 1 cycle, then sends 3 and 4 (last):
  - txd 1,2 on the wire;
  - then one nibble txd=0, txer=1;
  - txen=0 while 3,4 drain; then the IFG is enforced.
- Reset pulse (mac_mii_txrst=1 for 2 cycles) during the preamble:
  - txen falls immediately; all outputs are 0;
  - the next frame starts with a full 15-nibble preamble.
- Request from src1 arriving during src0's IFG: its preamble starts exactly 24 cycles after src0's last nibble, and ready stays 0 until its SFD cycle.

Source files
------------

// File: rtl/mii_tx_pkg.sv
// Shared types and constants for the MII transmit frame scheduler.
package mii_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    DATA,
    DRAIN,
    IFG
  } tx_state_e;

  localparam logic [3:0] MII_PREAMBLE_NIB   = 4'h5;
  localparam logic [3:0] MII_SFD_NIB        = 4'hD;
  localparam int         IFG_NIBBLES        = 24;
  localparam int         PREAMBLE_NIBBLES   = 15;

  // Wide enough for the longer of the IFG count and preamble+SFD count.
  function automatic int cnt_width(input int ifg, input int pre);
    int m;
    m = (ifg > pre + 1) ? ifg : pre + 1;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/mii_rr_arb2.sv
// Two-requester round-robin grant; the last-grant register only moves when a frame is started.
module mii_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  output logic       gnt,
  output logic       last_gnt
);

  // On a tie the source not served last wins; a lone request always wins.
  always_comb begin
    gnt = req[1];
    if (req == 2'b11) gnt = ~last_gnt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_gnt <= 1'b1;
    else if (update) last_gnt <= gnt;
  end

endmodule

// File: rtl/mii_tx_arbiter.sv
// Frame-level round-robin scheduler driving the MAC-side MII transmit port from two nibble sources.
module mii_tx_arbiter
  import mii_tx_pkg::*;
#(
  parameter int IFG_NIBBLES      = mii_tx_pkg::IFG_NIBBLES,
  parameter int PREAMBLE_NIBBLES = mii_tx_pkg::PREAMBLE_NIBBLES
) (
  input  logic       mac_mii_txc,
  input  logic       mac_mii_txrst,
  input  logic       src0_valid,
  output logic       src0_ready,
  input  logic [3:0] src0_data,
  input  logic       src0_last,
  input  logic       src0_err,
  input  logic       src1_valid,
  output logic       src1_ready,
  input  logic [3:0] src1_data,
  input  logic       src1_last,
  input  logic       src1_err,
  output logic       mac_mii_txen,
  output logic       mac_mii_txer,
  output logic [3:0] mac_mii_txd,
  output logic       busy,
  output logic       grant_id
);

  localparam int            CW       = cnt_width(IFG_NIBBLES, PREAMBLE_NIBBLES);
  localparam logic [CW-1:0] PRE_LAST = CW'(PREAMBLE_NIBBLES - 1);
  localparam logic [CW-1:0] IFG_LAST = CW'(IFG_NIBBLES - 1);

  tx_state_e     state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          txen_nxt, txer_nxt;
  logic [3:0]    txd_nxt;
  logic          arb_gnt, start;
  logic          sel_valid, sel_last, sel_err;
  logic [3:0]    sel_data;

  assign start = (state == IDLE) && (src0_valid || src1_valid);

  mii_rr_arb2 u_arb (
    .clk      (mac_mii_txc),
    .rst      (mac_mii_txrst),
    .req      ({src1_valid, src0_valid}),
    .update   (start),
    .gnt      (arb_gnt),
    .last_gnt (grant_id)
  );

  // grant_id is stable for the whole frame, so it doubles as the data mux select.
  assign sel_valid = grant_id ? src1_valid : src0_valid;
  assign sel_data  = grant_id ? src1_data  : src0_data;
  assign sel_last  = grant_id ? src1_last  : src0_last;
  assign sel_err   = grant_id ? src1_err   : src0_err;

  assign src0_ready = ((state == DATA) || (state == DRAIN)) && !grant_id;
  assign src1_ready = ((state == DATA) || (state == DRAIN)) &&  grant_id;
  assign busy       = (state != IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    txen_nxt  = 1'b0;
    txer_nxt  = 1'b0;
    txd_nxt   = 4'h0;
    case (state)
      IDLE: if (start) begin
        state_nxt = PRE;
        cnt_nxt   = '0;
        txen_nxt  = 1'b1;
        txd_nxt   = MII_PREAMBLE_NIB;
      end
      PRE: begin
        txen_nxt = 1'b1;
        if (cnt == PRE_LAST) begin
          txd_nxt   = MII_SFD_NIB;
          state_nxt = DATA;
        end else begin
          txd_nxt = MII_PREAMBLE_NIB;
          cnt_nxt = cnt + CW'(1);
        end
      end
      DATA: begin
        txen_nxt = 1'b1;
        if (sel_valid) begin
          txd_nxt  = sel_data;
          txer_nxt = sel_err;
          if (sel_last) begin
            state_nxt = IFG;
            cnt_nxt   = '0;
          end
        end else begin
          // Underrun: poison the frame with one error nibble, then swallow the rest.
          txer_nxt  = 1'b1;
          state_nxt = DRAIN;
        end
      end
      DRAIN: if (sel_valid && sel_last) begin
        state_nxt = IFG;
        cnt_nxt   = '0;
      end
      IFG: begin
        if (cnt == IFG_LAST) state_nxt = IDLE;
        else                 cnt_nxt   = cnt + CW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge mac_mii_txc or posedge mac_mii_txrst) begin
    if (mac_mii_txrst) begin
      state        <= IDLE;
      cnt          <= '0;
      mac_mii_txen <= 1'b0;
      mac_mii_txer <= 1'b0;
      mac_mii_txd  <= 4'h0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      mac_mii_txen <= txen_nxt;
      mac_mii_txer <= txer_nxt;
      mac_mii_txd  <= txd_nxt;
    end
  end

endmodule

// File: tb/tb_mii_tx_arbiter.sv
// Directed bench for mii_tx_arbiter: drives frames, logs the MII wire per cycle, checks hand-computed traces.
module tb_mii_tx_arbiter;

  localparam int LOGN = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       src0_valid = 1'b0, src0_ready, src0_last = 1'b0, src0_err = 1'b0;
  logic [3:0] src0_data = 4'h0;
  logic       src1_valid = 1'b0, src1_ready, src1_last = 1'b0, src1_err = 1'b0;
  logic [3:0] src1_data = 4'h0;
  logic       txen, txer, busy, grant_id;
  logic [3:0] txd;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic       log_en  [0:LOGN-1];
  logic       log_er  [0:LOGN-1];
  logic [3:0] log_d   [0:LOGN-1];
  logic       log_gnt [0:LOGN-1];
  logic       log_r0  [0:LOGN-1];
  logic       log_r1  [0:LOGN-1];

  mii_tx_arbiter dut (
    .mac_mii_txc   (clk),
    .mac_mii_txrst (rst),
    .src0_valid    (src0_valid),
    .src0_ready    (src0_ready),
    .src0_data     (src0_data),
    .src0_last     (src0_last),
    .src0_err      (src0_err),
    .src1_valid    (src1_valid),
    .src1_ready    (src1_ready),
    .src1_data     (src1_data),
    .src1_last     (src1_last),
    .src1_err      (src1_err),
    .mac_mii_txen  (txen),
    .mac_mii_txer  (txer),
    .mac_mii_txd   (txd),
    .busy          (busy),
    .grant_id      (grant_id)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cyc < LOGN) begin
      log_en[cyc]  <= txen;
      log_er[cyc]  <= txer;
      log_d[cyc]   <= txd;
      log_gnt[cyc] <= grant_id;
      log_r0[cyc]  <= src0_ready;
      log_r1[cyc]  <= src1_ready;
    end
    cyc <= cyc + 1;
  end

  task automatic sync;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int src, input logic v, input logic [3:0] d, input logic l, input logic e);
    if (src == 0) begin
      src0_valid = v; src0_data = d; src0_last = l; src0_err = e;
    end else begin
      src1_valid = v; src1_data = d; src1_last = l; src1_err = e;
    end
  endtask

  // Nibble i of the frame is d[4i+3:4i]; dropk inserts one valid-low cycle before nibble dropk.
  task automatic send(input int src, input logic [31:0] d, input int n, input int errk, input int dropk);
    int  i = 0;
    int  t = 0;
    bit  dropped = 0;
    bit  hs;
    while (i < n && t < 600) begin
      if (i == dropk && !dropped) begin
        drive(src, 1'b0, 4'h0, 1'b0, 1'b0);
        dropped = 1;
      end else begin
        drive(src, 1'b1, d[i*4 +: 4], (i == n - 1), (i == errk));
      end
      @(negedge clk);
      hs = (src == 0) ? (src0_valid && src0_ready) : (src1_valid && src1_ready);
      sync();
      if (hs) i++;
      t++;
    end
    drive(src, 1'b0, 4'h0, 1'b0, 1'b0);
    if (i < n) begin
      checks++; errors++;
      $display("FAIL send_timeout src%0d accepted %0d of %0d nibbles", src, i, n);
    end
  endtask

  function automatic int next_rise(input int from);
    for (int i = (from < 1 ? 1 : from); i < cyc && i < LOGN; i++)
      if (log_en[i] && !log_en[i-1]) return i;
    return -1;
  endfunction

  function automatic int run_len(input int st);
    int n = 0;
    while (st + n < cyc && st + n < LOGN && log_en[st+n]) n++;
    return n;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({txen, txer, txd} !== 6'b0) begin
      errors++; $display("FAIL reset_wire got en=%b er=%b d=%h want 0 0 0", txen, txer, txd);
    end
    checks++;
    if (busy !== 1'b0 || grant_id !== 1'b1) begin
      errors++; $display("FAIL reset_status got busy=%b grant=%b want 0 1", busy, grant_id);
    end
    checks++;
    if (src0_ready !== 1'b0 || src1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got %b%b want 00", src1_ready, src0_ready);
    end
    rst = 1'b0;
    repeat (3) sync();
    checks++;
    if (busy !== 1'b0 || txen !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset got busy=%b en=%b want 0 0", busy, txen);
    end
  endtask

  task automatic test_single;
    int s, r;
    s = cyc;
    send(0, 32'h4321, 4, -1, -1);
    repeat (40) sync();
    r = next_rise(s);
    checks++;
    if (r != s + 1) begin
      errors++; $display("FAIL single_start got %0d want %0d", r, s + 1);
      if (r < 0) return;
    end
    for (int k = 0; k < 20; k++) begin
      logic [3:0] e;
      e = (k < 15) ? 4'h5 : (k == 15) ? 4'hD : 4'(k - 15);
      checks++;
      if (log_en[r+k] !== 1'b1 || log_d[r+k] !== e || log_er[r+k] !== 1'b0) begin
        errors++; $display("FAIL single_nib%0d got en=%b d=%h er=%b want 1 %h 0", k, log_en[r+k], log_d[r+k], log_er[r+k], e);
      end
    end
    for (int k = 20; k < 44; k++) begin
      checks++;
      if (log_en[r+k] !== 1'b0) begin
        errors++; $display("FAIL single_ifg%0d got en=%b want 0", k, log_en[r+k]);
      end
    end
    checks++;
    if (log_gnt[r] !== 1'b0) begin
      errors++; $display("FAIL single_grant got %b want 0", log_gnt[r]);
    end
    checks++;
    if (log_r0[r+14] !== 1'b0 || log_r0[r+15] !== 1'b1) begin
      errors++; $display("FAIL single_ready_sfd got %b%b want 01", log_r0[r+14], log_r0[r+15]);
    end
  endtask

  task automatic test_back_to_back;
    int pos, st, ln, pend;
    logic [15:0] fdv;
    fdv = 16'hC491;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sync();
    pos = cyc;
    fork
      begin send(0, 32'h321, 3, -1, -1); send(0, 32'h654, 3, -1, -1); end
      begin send(1, 32'hBA9, 3, -1, -1); send(1, 32'hFEC, 3, -1, -1); end
    join
    repeat (40) sync();
    pend = -1;
    for (int i = 0; i < 4; i++) begin
      st = next_rise(pos);
      checks++;
      if (st < 0) begin
        errors++; $display("FAIL rr_frame%0d got no frame want frame", i);
        return;
      end
      ln = run_len(st);
      if (ln != 19 || log_gnt[st] !== 1'(i) || log_d[st+16] !== fdv[i*4 +: 4]) begin
        errors++; $display("FAIL rr_frame%0d got len=%0d grant=%b d0=%h want 19 %0d %h", i, ln, log_gnt[st], log_d[st+16], i % 2, fdv[i*4 +: 4]);
      end
      if (i > 0) begin
        checks++;
        if (st - pend != 24) begin
          errors++; $display("FAIL rr_gap%0d got %0d want 24", i, st - pend);
        end
      end
      pend = st + ln;
      pos  = pend;
    end
  endtask

  task automatic test_err;
    int s, r;
    s = cyc;
    send(1, 32'h654321, 6, 2, -1);
    repeat (40) sync();
    r = next_rise(s);
    checks++;
    if (r != s + 1) begin
      errors++; $display("FAIL err_start got %0d want %0d", r, s + 1);
      if (r < 0) return;
    end
    for (int k = 0; k < 23; k++) begin
      logic [3:0] e;
      logic       en;
      e  = (k < 15) ? 4'h5 : (k == 15) ? 4'hD : (k < 22) ? 4'(k - 15) : 4'h0;
      en = (k < 22);
      checks++;
      if (log_en[r+k] !== en || log_d[r+k] !== e || log_er[r+k] !== (k == 18)) begin
        errors++; $display("FAIL err_nib%0d got en=%b d=%h er=%b want %b %h %b", k, log_en[r+k], log_d[r+k], log_er[r+k], en, e, (k == 18));
      end
    end
    checks++;
    if (log_gnt[r] !== 1'b1) begin
      errors++; $display("FAIL err_grant got %b want 1", log_gnt[r]);
    end
  endtask

  task automatic test_underrun;
    int s, r, r2;
    s = cyc;
    send(0, 32'h4321, 4, -1, 2);
    send(0, 32'h98, 2, -1, -1);
    repeat (40) sync();
    r = next_rise(s);
    checks++;
    if (r != s + 1) begin
      errors++; $display("FAIL urun_start got %0d want %0d", r, s + 1);
      if (r < 0) return;
    end
    checks++;
    if (log_d[r+16] !== 4'h1 || log_d[r+17] !== 4'h2 || log_er[r+17] !== 1'b0) begin
      errors++; $display("FAIL urun_data got %h %h er=%b want 1 2 0", log_d[r+16], log_d[r+17], log_er[r+17]);
    end
    checks++;
    if (log_en[r+18] !== 1'b1 || log_er[r+18] !== 1'b1 || log_d[r+18] !== 4'h0) begin
      errors++; $display("FAIL urun_errnib got en=%b er=%b d=%h want 1 1 0", log_en[r+18], log_er[r+18], log_d[r+18]);
    end
    for (int k = 19; k < 45; k++) begin
      checks++;
      if (log_en[r+k] !== 1'b0 || log_er[r+k] !== 1'b0) begin
        errors++; $display("FAIL urun_quiet%0d got en=%b er=%b want 0 0", k, log_en[r+k], log_er[r+k]);
      end
    end
    checks++;
    if (log_r0[r+19] !== 1'b1) begin
      errors++; $display("FAIL urun_drain_ready got %b want 1", log_r0[r+19]);
    end
    r2 = next_rise(r + 1);
    checks++;
    if (r2 != r + 45) begin
      errors++; $display("FAIL urun_next_start got %0d want %0d", r2, r + 45);
    end
  endtask

  task automatic test_reset_mid;
    int s, r;
    drive(0, 1'b1, 4'h1, 1'b0, 1'b0);
    repeat (6) sync();
    #2;
    rst = 1'b1;
    drive(0, 1'b0, 4'h0, 1'b0, 1'b0);
    #1;
    checks++;
    if ({txen, txer, txd} !== 6'b0 || busy !== 1'b0 || grant_id !== 1'b1) begin
      errors++; $display("FAIL midreset got en=%b er=%b d=%h busy=%b grant=%b want 0 0 0 0 1", txen, txer, txd, busy, grant_id);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    s = cyc;
    send(0, 32'h87, 2, -1, -1);
    repeat (40) sync();
    r = next_rise(s);
    checks++;
    if (r != s + 1) begin
      errors++; $display("FAIL midreset_restart got %0d want %0d", r, s + 1);
      if (r < 0) return;
    end
    checks++;
    if (run_len(r) != 18) begin
      errors++; $display("FAIL midreset_len got %0d want 18", run_len(r));
    end
    for (int k = 0; k < 18; k++) begin
      logic [3:0] e;
      e = (k < 15) ? 4'h5 : (k == 15) ? 4'hD : (k == 16) ? 4'h7 : 4'h8;
      checks++;
      if (log_d[r+k] !== e || log_er[r+k] !== 1'b0) begin
        errors++; $display("FAIL midreset_nib%0d got d=%h er=%b want %h 0", k, log_d[r+k], log_er[r+k], e);
      end
    end
  endtask

  task automatic test_ifg_request;
    int s, s1, r0, r1;
    s = cyc;
    send(0, 32'h21, 2, -1, -1);
    repeat (5) sync();
    s1 = cyc;
    send(1, 32'h3, 1, -1, -1);
    repeat (40) sync();
    r0 = next_rise(s);
    r1 = (r0 < 0) ? -1 : next_rise(r0 + 1);
    checks++;
    if (r0 < 0 || r1 != r0 + 18 + 24) begin
      errors++; $display("FAIL ifgreq_start got r0=%0d r1=%0d want r1=r0+42", r0, r1);
      return;
    end
    for (int i = s1; i < r1 + 15; i++) begin
      checks++;
      if (log_r1[i] !== 1'b0) begin
        errors++; $display("FAIL ifgreq_ready_early at %0d got %b want 0", i - r1, log_r1[i]);
      end
    end
    checks++;
    if (log_r1[r1+15] !== 1'b1 || log_gnt[r1] !== 1'b1 || log_d[r1+16] !== 4'h3) begin
      errors++; $display("FAIL ifgreq_frame got ready=%b grant=%b d=%h want 1 1 3", log_r1[r1+15], log_gnt[r1], log_d[r1+16]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_err();
    test_underrun();
    test_reset_mid();
    test_ifg_request();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
